// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: frame state
// encodings and line levels, kept here so a future UART receiver can reuse them.
package fifo_uart_tx_pkg;

  // Frame states; the encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Line level driven while in a given state; data_bit is used only in DATA.
  function automatic logic line_level(input tx_state_e st, input logic data_bit);
    case (st)
      ST_START: line_level = START_LEVEL;
      ST_DATA:  line_level = data_bit;
      default:  line_level = IDLE_LEVEL;
    endcase
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO pull port as seen by the transmitter (master) and by the
// arbiter/FIFO side (slave).
interface fifo_uart_tx_if #(
  parameter int DW = 8
) ();
  logic          fifo_req;
  logic          fifo_gnt;
  logic          fifo_stb;
  logic          fifo_op;
  logic [DW-1:0] fifo_data_read;
  logic          fifo_empty;

  modport master (
    output fifo_req,
    output fifo_stb,
    output fifo_op,
    input  fifo_gnt,
    input  fifo_data_read,
    input  fifo_empty
  );

  modport slave (
    input  fifo_req,
    input  fifo_stb,
    input  fifo_op,
    output fifo_gnt,
    output fifo_data_read,
    output fifo_empty
  );
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit. Held at zero while clr is high so every frame starts
// with a full-length start bit.
module fifo_uart_tx_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [CW-1:0] cnt_r;

  // A tick is suppressed while cleared so nothing advances in IDLE.
  assign bit_tick = (cnt_r == CNT_LAST) & ~clr;

  // Bit-period counter; wraps on the bit boundary, never overflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (clr || bit_tick) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain side: pulls one word per frame through the shared FIFO port
// and sends it as start bit, DW data bits LSB first, stop bit.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy
);
  localparam int BW = $clog2(DW + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO = BW'(0);

  tx_state_e     state_r, next_state_s;
  logic [DW-1:0] shift_r, shift_next_s;
  logic [BW-1:0] bit_cnt_r, bit_cnt_next_s;
  logic          tx_r, busy_r;
  logic          req_s, pull_s, bit_tick_s, baud_clr_s;

  // Request only from IDLE; reset masks it so no pull can slip through.
  assign req_s      = (state_r == ST_IDLE) & ~fifo.fifo_empty & ~rst;
  assign pull_s     = req_s & fifo.fifo_gnt;
  assign baud_clr_s = (state_r == ST_IDLE);

  assign fifo.fifo_req = req_s;
  assign fifo.fifo_stb = pull_s;
  assign fifo.fifo_op  = 1'b1;
  assign tx            = tx_r;
  assign busy          = busy_r;

  fifo_uart_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr_s),
    .bit_tick (bit_tick_s)
  );

  // Next-state, shift and bit-count logic for the frame sequencer.
  always_comb begin
    next_state_s   = state_r;
    shift_next_s   = shift_r;
    bit_cnt_next_s = bit_cnt_r;
    case (state_r)
      ST_IDLE: begin
        bit_cnt_next_s = BIT_ZERO;
        if (pull_s) begin
          next_state_s = ST_START;
          shift_next_s = fifo.fifo_data_read;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_tick_s) begin
          next_state_s = ST_DATA;
        end else begin
          next_state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_tick_s) begin
          shift_next_s = {1'b0, shift_r[DW-1:1]};
          if (bit_cnt_r == BIT_LAST) begin
            next_state_s   = ST_STOP;
            bit_cnt_next_s = BIT_ZERO;
          end else begin
            next_state_s   = ST_DATA;
            bit_cnt_next_s = bit_cnt_r + BIT_ONE;
          end
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bit_tick_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_STOP;
        end
      end
      default: begin
        next_state_s   = ST_IDLE;
        bit_cnt_next_s = BIT_ZERO;
      end
    endcase
  end

  // State and datapath registers; tx/busy are registered from the next
  // state so the line falls on the very edge that closes the pull cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= {DW{1'b0}};
      bit_cnt_r <= BIT_ZERO;
      tx_r      <= IDLE_LEVEL;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      shift_r   <= shift_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      tx_r      <= line_level(next_state_s, shift_next_s[0]);
      busy_r    <= (next_state_s != ST_IDLE);
    end
  end
endmodule
